// File: rtl/ibex_l2_banked_register_file.sv
// Banked scratch/shadow register file: one byte-enabled write port, a configurable
// number of registered read ports with write-to-read bypass, and a clear sequencer
// that zeroes every word after reset or on request.
module ibex_l2_banked_register_file #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned NumWords     = 32,
    parameter int unsigned NumReadPorts = 2,
    parameter bit          ZeroWord0    = 1'b1,
    localparam int unsigned AddrWidth   = $clog2(NumWords),
    localparam int unsigned BeWidth     = DataWidth / 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clear_i,
    output logic                              busy_o,
    input  logic                              we_i,
    input  logic [AddrWidth-1:0]              waddr_i,
    input  logic [DataWidth-1:0]              wdata_i,
    input  logic [BeWidth-1:0]                wbe_i,
    output logic                              werr_o,
    input  logic [NumReadPorts-1:0]           re_i,
    input  logic [NumReadPorts*AddrWidth-1:0] raddr_i,
    output logic [NumReadPorts*DataWidth-1:0] rdata_o,
    output logic [NumReadPorts-1:0]           rvalid_o,
    output logic [NumReadPorts-1:0]           rerr_o
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    // Last word index swept by the clear sequencer, and the word count widened by
    // one bit so that range checks work when NumWords is a power of two.
    localparam logic [AddrWidth-1:0] LastIdx     = AddrWidth'(NumWords - 1);
    localparam logic [AddrWidth:0]   NumWordsExt = (AddrWidth + 1)'(NumWords);

    state_e                         state_q, state_d;
    logic [AddrWidth-1:0]           cnt_q, cnt_d;
    logic                           idle;

    logic [DataWidth-1:0]           mem_q [NumWords];

    logic                           waddr_ok;
    logic                           waddr_zero;
    logic [AddrWidth-1:0]           waddr_idx;
    logic                           wr_acc;
    logic [DataWidth-1:0]           wr_word;
    logic                           werr_d, werr_q;

    logic [AddrWidth-1:0]           raddr [NumReadPorts];
    logic [AddrWidth-1:0]           rd_idx [NumReadPorts];
    logic [DataWidth-1:0]           rd_word [NumReadPorts];
    logic [NumReadPorts-1:0]        rd_ok;
    logic [NumReadPorts-1:0]        rd_acc;

    logic [NumReadPorts*DataWidth-1:0] rdata_q;
    logic [NumReadPorts-1:0]           rvalid_q;
    logic [NumReadPorts-1:0]           rerr_q;

    assign idle   = (state_q == ST_IDLE);
    assign busy_o = (state_q == ST_CLEAR);

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------

    // Next-state logic: sweep cnt over all words in CLEAR, re-arm on clear_i.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (clear_i) begin
                    cnt_d = '0;
                end else if (cnt_q == LastIdx) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AddrWidth'(1);
                end
            end
            ST_IDLE: begin
                if (clear_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // State register: reset lands in CLEAR so storage is zeroed before first use.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values, independent of block ordering.
        if (rst_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Write port
    // ------------------------------------------------------------------

    assign waddr_ok   = ({1'b0, waddr_i} < NumWordsExt);
    assign waddr_zero = ZeroWord0 && (waddr_i == '0);
    // Out-of-range addresses never index storage; they are folded onto word 0.
    assign waddr_idx  = waddr_ok ? waddr_i : '0;
    assign wr_acc     = idle & we_i & waddr_ok & ~waddr_zero;
    // Word 0 with ZeroWord0 is a silent drop, so it is not part of the error term.
    assign werr_d     = we_i & (~idle | ~waddr_ok);

    // Merge the write bytes into the current word; shared by storage and bypass.
    always_comb begin
        wr_word = mem_q[waddr_idx];
        for (int b = 0; b < BeWidth; b++) begin
            if (wbe_i[b]) begin
                wr_word[b*8 +: 8] = wdata_i[b*8 +: 8];
            end
        end
    end

    // Storage update: clear sweep has priority; writes only land while idle.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array has no reset; the clear sequencer zeroes it,
        // which keeps it mappable to plain flops or distributed RAM.
        if (state_q == ST_CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_acc) begin
            mem_q[waddr_idx] <= wr_word;
        end
    end

    // Write-error pulse, one cycle after the dropped write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            werr_q <= 1'b0;
        end else begin
            werr_q <= werr_d;
        end
    end

    assign werr_o = werr_q;

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------

    assign rd_acc = re_i & {NumReadPorts{idle}};

    // Per-port read data selection: range check, zero word, bypass, storage.
    always_comb begin
        for (int p = 0; p < NumReadPorts; p++) begin
            raddr[p]   = raddr_i[p*AddrWidth +: AddrWidth];
            rd_ok[p]   = ({1'b0, raddr[p]} < NumWordsExt);
            rd_idx[p]  = rd_ok[p] ? raddr[p] : '0;
            rd_word[p] = '0;
            if (rd_ok[p] && !(ZeroWord0 && (raddr[p] == '0))) begin
                if (wr_acc && (waddr_i == raddr[p])) begin
                    rd_word[p] = wr_word;
                end else begin
                    rd_word[p] = mem_q[rd_idx[p]];
                end
            end
        end
    end

    // Read output registers: data/err hold until the next accepted read per port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= '0;
            rerr_q   <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rd_acc;
            for (int p = 0; p < NumReadPorts; p++) begin
                if (rd_acc[p]) begin
                    rdata_q[p*DataWidth +: DataWidth] <= rd_word[p];
                    rerr_q[p]                         <= ~rd_ok[p];
                end
            end
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign rerr_o   = rerr_q;

endmodule

// File: tb/tb_ibex_l2_banked_register_file.sv
// Self-checking bench for ibex_l2_banked_register_file: table-driven vectors plus
// hand-written clear/reset/out-of-range sequences, with a per-port read scoreboard.
module tb_ibex_l2_banked_register_file;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rd_exp_t;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wbe;
        logic [1:0]  re;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic        exp_werr;
    } vec_t;

    logic        clk;
    logic        rst;

    // Main instance: 32 words
    logic        clear, busy, we, werr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic [1:0]  re, rvalid, rerr;
    logic [9:0]  raddr;
    logic [63:0] rdata;

    // Second instance: 24 words, for out-of-range behaviour
    logic        clear24, busy24, we24, werr24;
    logic [4:0]  waddr24;
    logic [31:0] wdata24;
    logic [3:0]  wbe24;
    logic [1:0]  re24, rvalid24, rerr24;
    logic [9:0]  raddr24;
    logic [63:0] rdata24;

    int          n_cmp;
    int          n_mis;
    logic        exp_werr;
    rd_exp_t     sb0[$];
    rd_exp_t     sb1[$];
    vec_t        vecs[11];

    ibex_l2_banked_register_file #(
        .DataWidth(32), .NumWords(32), .NumReadPorts(2), .ZeroWord0(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe), .werr_o(werr),
        .re_i(re), .raddr_i(raddr), .rdata_o(rdata), .rvalid_o(rvalid), .rerr_o(rerr)
    );

    ibex_l2_banked_register_file #(
        .DataWidth(32), .NumWords(24), .NumReadPorts(2), .ZeroWord0(1'b1)
    ) dut24 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear24), .busy_o(busy24),
        .we_i(we24), .waddr_i(waddr24), .wdata_i(wdata24), .wbe_i(wbe24), .werr_o(werr24),
        .re_i(re24), .raddr_i(raddr24), .rdata_o(rdata24), .rvalid_o(rvalid24), .rerr_o(rerr24)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_rd(input int p, input logic [31:0] d, input logic e_err);
        rd_exp_t e;
        e.data = d;
        e.err  = e_err;
        if (p == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    function automatic logic [31:0] fill_val(input int i);
        return 32'h1000_0000 | (32'(i) << 8) | 32'(i);
    endfunction

    // Advance one clock, drop single-cycle requests, then check the main instance.
    task automatic step();
        rd_exp_t e;
        @(posedge clk);
        #1;
        we = 1'b0; re = '0; clear = 1'b0;
        we24 = 1'b0; re24 = '0; clear24 = 1'b0;
        check("werr", 64'(werr), 64'(exp_werr));
        exp_werr = 1'b0;
        check("rvalid0", 64'(rvalid[0]), 64'(sb0.size() != 0));
        if (sb0.size() != 0) begin
            e = sb0.pop_front();
            if (rvalid[0]) begin
                check("rdata0", 64'(rdata[31:0]), 64'(e.data));
                check("rerr0", 64'(rerr[0]), 64'(e.err));
            end
        end
        check("rvalid1", 64'(rvalid[1]), 64'(sb1.size() != 0));
        if (sb1.size() != 0) begin
            e = sb1.pop_front();
            if (rvalid[1]) begin
                check("rdata1", 64'(rdata[63:32]), 64'(e.data));
                check("rerr1", 64'(rerr[1]), 64'(e.err));
            end
        end
    endtask

    // Count cycles while busy is high (bounded).
    task automatic count_busy(input string name, input int exp_cycles);
        int n;
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        check(name, 64'(n), 64'(exp_cycles));
    endtask

    task automatic read_all_zero();
        for (int i = 0; i < 32; i++) begin
            re = 2'b11;
            raddr = {5'(31 - i), 5'(i)};
            expect_rd(0, 32'h0, 1'b0);
            expect_rd(1, 32'h0, 1'b0);
            step();
        end
    endtask

    initial begin
        n_cmp = 0; n_mis = 0; exp_werr = 1'b0;
        rst = 1'b1;
        clear = 0; we = 0; waddr = 0; wdata = 0; wbe = 0; re = 0; raddr = 0;
        clear24 = 0; we24 = 0; waddr24 = 0; wdata24 = 0; wbe24 = 0; re24 = 0; raddr24 = 0;

        //          we    waddr  wdata          wbe    re     ra0    ra1    exp0           exp1           werr
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 4'hF, 2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b1, 5'd5,  32'h000000AA, 4'h1, 2'b01, 5'd5,  5'd0,  32'hDEADBEAA, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        4'h0, 2'b11, 5'd5,  5'd5,  32'hDEADBEAA, 32'hDEADBEAA, 1'b0};
        vecs[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 4'hF, 2'b01, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        4'h0, 2'b10, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
        vecs[5]  = '{1'b1, 5'd7,  32'h12345678, 4'hF, 2'b11, 5'd7,  5'd7,  32'h12345678, 32'h12345678, 1'b0};
        vecs[6]  = '{1'b1, 5'd7,  32'hAABBCCDD, 4'h5, 2'b11, 5'd7,  5'd5,  32'h12BB56DD, 32'hDEADBEAA, 1'b0};
        vecs[7]  = '{1'b1, 5'd5,  32'hFFFFFFFF, 4'h0, 2'b10, 5'd0,  5'd5,  32'h0,        32'hDEADBEAA, 1'b0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        4'h0, 2'b11, 5'd7,  5'd5,  32'h12BB56DD, 32'hDEADBEAA, 1'b0};
        vecs[9]  = '{1'b1, 5'd31, 32'hCAFEF00D, 4'hF, 2'b11, 5'd31, 5'd30, 32'hCAFEF00D, 32'h0,        1'b0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        4'h0, 2'b11, 5'd30, 5'd31, 32'h0,        32'hCAFEF00D, 1'b0};

        // Reset values while reset is held, then the initial clear sweep.
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd1);
        check("reset_rvalid", 64'(rvalid), 64'd0);
        check("reset_rerr", 64'(rerr), 64'd0);
        check("reset_werr", 64'(werr), 64'd0);
        check("reset_rdata", rdata, 64'd0);
        rst = 1'b0;
        count_busy("busy_after_reset", 32);
        read_all_zero();

        // Table-driven write/read/bypass vectors.
        for (int i = 0; i < 11; i++) begin
            we    = vecs[i].we;
            waddr = vecs[i].waddr;
            wdata = vecs[i].wdata;
            wbe   = vecs[i].wbe;
            re    = vecs[i].re;
            raddr = {vecs[i].ra1, vecs[i].ra0};
            if (vecs[i].re[0]) expect_rd(0, vecs[i].exp0, 1'b0);
            if (vecs[i].re[1]) expect_rd(1, vecs[i].exp1, 1'b0);
            exp_werr = vecs[i].exp_werr;
            step();
        end
        check("rdata_hold0", 64'(rdata[31:0]), 64'h0);
        step();
        check("rdata_hold1", 64'(rdata[63:32]), 64'hCAFEF00D);

        // 24-word instance: out-of-range write and reads.
        we24 = 1'b1; waddr24 = 5'd30; wdata24 = 32'hFFFFFFFF; wbe24 = 4'hF;
        re24 = 2'b01; raddr24 = {5'd0, 5'd30};
        step();
        check("w24_oor_werr", 64'(werr24), 64'd1);
        check("w24_oor_rvalid", 64'(rvalid24), 64'd1);
        check("w24_oor_rdata", 64'(rdata24[31:0]), 64'd0);
        check("w24_oor_rerr", 64'(rerr24[0]), 64'd1);
        we24 = 1'b1; waddr24 = 5'd23; wdata24 = 32'h55AA55AA; wbe24 = 4'hF;
        re24 = 2'b10; raddr24 = {5'd23, 5'd0};
        step();
        check("w24_last_werr", 64'(werr24), 64'd0);
        check("w24_last_rvalid", 64'(rvalid24), 64'd2);
        check("w24_last_rdata", 64'(rdata24[63:32]), 64'h55AA55AA);
        check("w24_hold_rerr", 64'(rerr24), 64'd1);
        re24 = 2'b11; raddr24 = {5'd23, 5'd24};
        step();
        check("w24_edge_rvalid", 64'(rvalid24), 64'd3);
        check("w24_edge_rerr", 64'(rerr24), 64'd1);
        check("w24_edge_rdata", rdata24, {32'h55AA55AA, 32'h0});

        // Clear together with a read returns pre-clear data; reset at cnt = 10.
        clear = 1'b1; re = 2'b01; raddr = {5'd0, 5'd5};
        expect_rd(0, 32'hDEADBEAA, 1'b0);
        step();
        check("busy_after_clear", 64'(busy), 64'd1);
        for (int i = 0; i < 10; i++) step();
        check("busy_mid_clear", 64'(busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midclr_rst_busy", 64'(busy), 64'd1);
        check("midclr_rst_rdata", rdata, 64'd0);
        check("midclr_rst_rvalid", 64'(rvalid), 64'd0);
        check("midclr_rst_werr", 64'(werr), 64'd0);
        check("midclr_rst_rerr24", 64'(rerr24), 64'd0);
        check("midclr_rst_rdata24", rdata24, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_busy("busy_after_midclr_reset", 32);

        // Fill words 1..31, read back, then clear with accesses during busy.
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = fill_val(i); wbe = 4'hF;
            step();
        end
        for (int i = 0; i < 32; i++) begin
            re = 2'b11;
            raddr = {5'(31 - i), 5'(i)};
            expect_rd(0, (i == 0) ? 32'h0 : fill_val(i), 1'b0);
            expect_rd(1, (i == 31) ? 32'h0 : fill_val(31 - i), 1'b0);
            step();
        end
        clear = 1'b1;
        step();
        begin
            int n;
            n = 0;
            while (busy && n < 100) begin
                if (n == 5) begin
                    we = 1'b1; waddr = 5'd3; wdata = 32'hFFFFFFFF; wbe = 4'hF;
                    re = 2'b11; raddr = {5'd31, 5'd31};
                    exp_werr = 1'b1;
                end
                step();
                n++;
            end
            check("busy_after_clear_req", 64'(n), 64'd32);
        end
        check("rdata_hold_busy", 64'(rdata[31:0]), 64'(fill_val(31)));
        read_all_zero();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
